// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants and types for the M-extension unit.
// Provides XLEN, the funct3 encodings of the eight M ops and the MDU FSM state type.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_t;

endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement negation, W bits wide.
// Ports: neg (negate when 1), din (value in), dout (din or -din, modulo 2^W).
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add / restoring divide).
// Ports: clk, rst (sync, active high), start, funct3, op_a, op_b -> busy, done, result.
module muldiv_unit #(
    parameter int XLEN  = rv32_pkg::XLEN,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import rv32_pkg::*;

    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN);

    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] p_q, p_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic              spec_q, spec_d;

    logic              sgn_a, sgn_b, neg_a, neg_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   abs_a, abs_b, spec_val;
    logic [XLEN:0]     mul_sum, rem_sh, trial;
    logic              q_bit, is_mul;
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        unique case (funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            F3_MULHSU: sgn_a = 1'b1;
            default: ;
        endcase
    end

    assign neg_a = sgn_a & op_a[XLEN-1];
    assign neg_b = sgn_b & op_b[XLEN-1];

    mdu_negate #(.W(XLEN)) u_abs_a (.neg(neg_a), .din(op_a), .dout(abs_a));
    mdu_negate #(.W(XLEN)) u_abs_b (.neg(neg_b), .din(op_b), .dout(abs_b));

    // Divide corner cases resolve at accept and skip the iteration entirely.
    assign div_zero = funct3[2] && (op_b == '0);
    assign div_ovf  = (funct3 == F3_DIV || funct3 == F3_REM)
                    && (op_a == MIN_NEG) && (op_b == '1);

    always_comb begin
        if (div_zero) spec_val = funct3[1] ? op_a : '1;
        else          spec_val = funct3[1] ? '0 : MIN_NEG;
    end

    // One shift-add step: upper half + multiplicand, then shift right by one.
    assign mul_sum = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, (p_q[0] ? m_q : '0)};

    // One restoring step: shift the next dividend bit in, keep the trial if it fits.
    assign rem_sh = {rem_q[XLEN-1:0], p_q[XLEN-1]};
    assign trial  = rem_sh - {1'b0, m_q};
    assign q_bit  = ~trial[XLEN];

    assign is_mul = ~f3_q[2];

    always_comb begin
        if (is_mul)       fix_in = p_q;
        else if (f3_q[1]) fix_in = {{(XLEN-1){1'b0}}, rem_q};
        else              fix_in = {{XLEN{1'b0}}, p_q[XLEN-1:0]};
    end

    mdu_negate #(.W(2*XLEN)) u_fix (.neg(neg_q), .din(fix_in), .dout(fix_out));

    assign fix_res = (is_mul && f3_q[1:0] != 2'b00) ? fix_out[2*XLEN-1:XLEN]
                                                    : fix_out[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        rem_d    = rem_q;
        m_d      = m_q;
        result_d = result_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        spec_d   = spec_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    f3_d   = funct3;
                    cnt_d  = '0;
                    spec_d = div_zero | div_ovf;
                    if (div_zero | div_ovf) begin
                        // FIX then just forwards the preset value.
                        p_d     = {{XLEN{1'b0}}, spec_val};
                        rem_d   = {1'b0, spec_val};
                        m_d     = '0;
                        neg_d   = 1'b0;
                        state_d = FIX;
                    end else begin
                        rem_d   = '0;
                        state_d = CALC;
                        if (funct3[2]) begin
                            p_d   = {{XLEN{1'b0}}, abs_a};
                            m_d   = abs_b;
                            neg_d = funct3[1] ? neg_a : (neg_a ^ neg_b);
                        end else begin
                            p_d   = {{XLEN{1'b0}}, abs_b};
                            m_d   = abs_a;
                            neg_d = neg_a ^ neg_b;
                        end
                    end
                end
            end
            CALC: begin
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (f3_q[2]) begin
                        rem_d = q_bit ? trial : rem_sh;
                        p_d   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-2:0], q_bit};
                    end else begin
                        p_d = {mul_sum, p_q[XLEN-1:1]};
                    end
                end
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            rem_q    <= '0;
            m_q      <= '0;
            result_q <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            rem_q    <= rem_d;
            m_q      <= m_d;
            result_q <= result_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            spec_q   <= spec_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX && !spec_q);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors plus a cycle-level reference model.
// Checks busy/done/result every cycle and pins literal results and latencies.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        int          sa, sb;
        longint      la, lb, ub;
        logic [63:0] p;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        ub = {32'h0, b};
        case (f)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = la * lb; return p[63:32]; end
            3'd2: begin p = la * ub; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF;
    endfunction

    // Timeline model: cycles remaining until done, result captured at accept.
    int          m_left = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    logic [31:0] m_res  = 0;
    logic [31:0] m_pend = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_busy = 0;
            m_done = 0;
            m_res  = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
                m_res  = m_pend;
            end
        end else if (start) begin
            m_pend = ref_op(funct3, op_a, op_b);
            if (is_special(funct3, op_a, op_b)) begin
                m_left = 1;
                m_busy = 0;
            end else begin
                m_left = 34;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'b0, busy}, {31'b0, m_busy});
        chk("done", {31'b0, done}, {31'b0, m_done});
        if (m_left == 0) chk("result", result, m_res);
    end

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[17] = '{
        '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34},
        '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34},
        '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34},
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34},
        '{3'd4, 32'hFFFFFFEC, 32'h00000006, 32'hFFFFFFFD, 34},
        '{3'd6, 32'hFFFFFFEC, 32'h00000006, 32'hFFFFFFFE, 34},
        '{3'd5, 32'd100,      32'd7,        32'd14,       34},
        '{3'd7, 32'd100,      32'd7,        32'd2,        34},
        '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1},
        '{3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
        '{3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 1},
        '{3'd4, 32'h80000000, 32'd2,        32'hC0000000, 34},
        '{3'd7, 32'h80000000, 32'd3,        32'd2,        34},
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34},
        '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        34}
    };

    // Accept one op, scramble inputs afterwards, measure latency and busy time.
    task automatic run_op(input string name, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int k;
        int nb;
        bit got;
        k   = 0;
        nb  = 0;
        got = 0;
        @(posedge clk);
        #1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = ~f;
        op_a   = ~a;
        op_b   = a ^ b;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                got = 1;
                break;
            end
            @(posedge clk);
            k++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within 60 cycles", name);
        end else begin
            chk(name, result, exp);
            chk({name, "_lat"}, k, exp_lat);
            chk({name, "_busy"}, nb, (exp_lat == 1) ? 0 : 34);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a,
                   vecs[i].b, vecs[i].r, vecs[i].lat);

        // Starts while busy are dropped, not queued.
        @(posedge clk);
        #1;
        funct3 = 3'd3;
        op_a   = 32'h00010000;
        op_b   = 32'h00010000;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dn = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) dn++;
            if (c == 5 || c == 20) begin
                start  = 1'b1;
                funct3 = 3'd0;
                op_a   = 32'd5;
                op_b   = 32'd7;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("ignore_done_count", dn, 1);
        chk("ignore_result", result, 32'd1);

        // A start seen only in the DONE cycle is dropped.
        run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, 34);
        funct3 = 3'd5;
        op_a   = 32'd9;
        op_b   = 32'd3;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_start_busy", {31'b0, busy}, 32'd0);
        chk("done_start_hold", result, 32'd12);

        // Reset mid-CALC aborts with no partial result.
        @(posedge clk);
        #1;
        funct3 = 3'd3;
        op_a   = 32'hFFFFFFFF;
        op_b   = 32'hFFFFFFFF;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_result", result, 32'd0);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("abort_no_done", dn, 0);
        run_op("mulhu_after_rst", 3'd3, 32'h80000000, 32'd2, 32'd1, 34);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
